// File: rtl/bsh_cmd_queue.sv
//------------------------------------------------------------------------------
// bsh_cmd_queue
//
// Command buffer and result-capture stage for a 32-bit combinational barrel
// rotator. Rotate commands {data, dir, amount} arrive over a valid/ready
// interface and are held in a DEPTH-entry FIFO. The FIFO head is presented to
// the external rotator on sh_*. The rotator's result (sh_result) is captured
// into an output register that has its own valid/ready handshake, so the
// rotator can sit in a pipelined, back-pressured datapath.
//
// Parameters
//   DEPTH     - number of FIFO entries; power of two, at least 2
//   CNT_W     - width of the completed-command counter
//
// Ports
//   clk       - single clock, all state changes on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - a command is offered
//   in_ready  - FIFO has room (level < DEPTH)
//   in_data   - operand to rotate
//   in_dir    - 1 = rotate right, 0 = rotate left
//   in_sh     - rotate amount 0..31
//   sh_data   - FIFO head operand to the rotator (0 when empty)
//   sh_dir    - FIFO head direction to the rotator (0 when empty)
//   sh_amt    - FIFO head amount to the rotator (0 when empty)
//   sh_result - combinational rotator output for the current sh_* values
//   out_valid - registered result available
//   out_ready - consumer accepts the result
//   out_data  - registered rotated word
//   level     - current FIFO occupancy, 0..DEPTH
//   done_cnt  - number of results taken by the consumer, wraps
//------------------------------------------------------------------------------
module bsh_cmd_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_data,
   input  logic                     in_dir,
   input  logic [4:0]               in_sh,
   output logic [31:0]              sh_data,
   output logic                     sh_dir,
   output logic [4:0]               sh_amt,
   input  logic [31:0]              sh_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         done_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   // FIFO storage, kept as three parallel arrays so each field has its
   // natural width.
   logic [31:0]   mem_data [DEPTH];
   logic          mem_dir  [DEPTH];
   logic [4:0]    mem_amt  [DEPTH];

   // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH
   // for free; full/empty is tracked separately by level.
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          consume;

   // Handshake decode. in_ready depends on occupancy alone, so upstream never
   // sees a combinational path from out_ready. A pop happens whenever there
   // is a command waiting and the output register is empty or being drained
   // in this same cycle.
   assign fifo_empty = (level == '0);
   assign in_ready   = (level < FULL_LEVEL);
   assign push       = in_valid & in_ready;
   assign consume    = out_valid & out_ready;
   assign pop        = ~fifo_empty & (~out_valid | out_ready);

   // The head entry drives the rotator directly. It is forced to zero when
   // the FIFO is empty so the rotator sees a clean, deterministic input
   // rather than whatever stale entry rd_ptr points at.
   assign sh_data = fifo_empty ? 32'd0 : mem_data[rd_ptr];
   assign sh_dir  = fifo_empty ? 1'b0  : mem_dir[rd_ptr];
   assign sh_amt  = fifo_empty ? 5'd0  : mem_amt[rd_ptr];

   // FIFO storage write. The contents are don't-care after reset, so the
   // array carries no reset; only the pointers and level define what is
   // valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= in_data;
         mem_dir[wr_ptr]  <= in_dir;
         mem_amt[wr_ptr]  <= in_sh;
      end
   end

   // Pointer and occupancy bookkeeping. A simultaneous push and pop moves
   // both pointers and leaves level unchanged. A push into an empty FIFO
   // only becomes visible at the head on the following cycle, because pop
   // is decided from the pre-edge level.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Output register. On a pop the rotator's result for the current head is
   // captured. If nothing is popped but the consumer takes the held result,
   // the register goes empty while out_data keeps its last value. With
   // out_ready low and no pop, both out_valid and out_data hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= 32'd0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_data  <= sh_result;
      end else if (consume) begin
         out_valid <= 1'b0;
      end
   end

   // Completed-command counter, bumped once per accepted result and left to
   // wrap naturally at its width.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_cnt <= '0;
      end else if (consume) begin
         done_cnt <= done_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bsh_cmd_queue.sv
//------------------------------------------------------------------------------
// tb_bsh_cmd_queue
//
// Self-checking bench for bsh_cmd_queue. The external rotator is modelled
// here as a plain bit-by-bit rotate. The reference model is a command queue
// plus an output slot, stepped once per clock from the handshake rules.
//------------------------------------------------------------------------------
module tb_bsh_cmd_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [31:0] data;
      logic        dir;
      logic [4:0]  sh;
   } cmd_t;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [31:0]             in_data;
   logic                    in_dir;
   logic [4:0]              in_sh;
   logic [31:0]             sh_data;
   logic                    sh_dir;
   logic [4:0]              sh_amt;
   logic [31:0]             sh_result;
   logic                    out_valid;
   logic                    out_ready;
   logic [31:0]             out_data;
   logic [$clog2(DEPTH):0]  level;
   logic [CNT_W-1:0]        done_cnt;

   // Reference model state
   cmd_t        model_q[$];
   logic        m_valid;
   logic [31:0] m_data;
   int          m_done;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        last_ready;

   always #5 clk = ~clk;

   // Behavioural rotator: rotate one bit at a time, s times
   function automatic logic [31:0] rotate(input logic [31:0] d, input logic dir,
                                          input logic [4:0] s);
      logic [31:0] r;
      r = d;
      for (int i = 0; i < int'(s); i++) begin
         r = dir ? {r[0], r[31:1]} : {r[30:0], r[31]};
      end
      return r;
   endfunction

   assign sh_result = rotate(sh_data, sh_dir, sh_amt);

   bsh_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dir    (in_dir),
      .in_sh     (in_sh),
      .sh_data   (sh_data),
      .sh_dir    (sh_dir),
      .sh_amt    (sh_amt),
      .sh_result (sh_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .done_cnt  (done_cnt)
   );

   // Drive one cycle of stimulus, advance one clock, then step the model.
   // The DUT's pre-edge in_ready is recorded in last_ready.
   task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic dir,
                                 input logic [4:0] s, input logic ordy);
      cmd_t c;
      logic acc;
      logic pop_m;
      in_valid   = v;
      in_data    = d;
      in_dir     = dir;
      in_sh      = s;
      out_ready  = ordy;
      last_ready = in_ready;
      acc   = v && (model_q.size() < DEPTH);
      pop_m = (model_q.size() != 0) && (!m_valid || ordy);
      @(posedge clk);
      #1;
      if (m_valid && ordy) m_done = (m_done + 1) % (1 << CNT_W);
      if (pop_m) begin
         c       = model_q.pop_front();
         m_data  = rotate(c.data, c.dir, c.sh);
         m_valid = 1'b1;
      end else if (m_valid && ordy) begin
         m_valid = 1'b0;
      end
      if (acc) begin
         c.data = d;
         c.dir  = dir;
         c.sh   = s;
         model_q.push_back(c);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_q.delete();
      m_valid = 1'b0;
      m_data  = 32'd0;
      m_done  = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (level !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++;
      if (out_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
      n_checks++;
      if (done_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_done_cnt: got %0d want 0", done_cnt); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++;
      if ({sh_data, sh_dir, sh_amt} !== 38'd0) begin
         n_fail++; $display("[TB] FAIL reset_sh_empty: got %h/%b/%0d want 0", sh_data, sh_dir, sh_amt);
      end
   endtask

   task automatic test_single();
      do_reset();
      apply_stimulus(1'b1, 32'h8000_0001, 1'b1, 5'd1, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0 || level !== 3'd1) begin
         n_fail++; $display("[TB] FAIL single_edge1: got valid=%b level=%0d want valid=0 level=1", out_valid, level);
      end
      apply_stimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hC000_0000) begin
         n_fail++; $display("[TB] FAIL single_result: got valid=%b data=%h want valid=1 data=c0000000", out_valid, out_data);
      end
      apply_stimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      n_checks++;
      if (done_cnt !== 4'd1 || out_valid !== 1'b0) begin
         n_fail++; $display("[TB] FAIL single_done: got done=%0d valid=%b want done=1 valid=0", done_cnt, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d_tab [3];
      logic        r_tab [3];
      logic [4:0]  s_tab [3];
      logic [31:0] exp_tab [3];
      d_tab = '{32'h1234_5678, 32'h1234_5678, 32'h0000_00FF};
      r_tab = '{1'b0, 1'b1, 1'b0};
      s_tab = '{5'd4, 5'd8, 5'd16};
      exp_tab = '{32'h2345_6781, 32'h7812_3456, 32'h00FF_0000};
      do_reset();
      for (int k = 0; k < 6; k++) begin
         if (k < 3) apply_stimulus(1'b1, d_tab[k], r_tab[k], s_tab[k], 1'b1);
         else       apply_stimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
         if (k >= 1 && k <= 3) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_tab[k-1]) begin
               n_fail++;
               $display("[TB] FAIL b2b_result%0d: got valid=%b data=%h want valid=1 data=%h",
                        k - 1, out_valid, out_data, exp_tab[k-1]);
            end
         end
      end
      n_checks++;
      if (done_cnt !== 4'd3) begin n_fail++; $display("[TB] FAIL b2b_done: got %0d want 3", done_cnt); end
   endtask

   task automatic test_full();
      int          accepted;
      logic [31:0] first_res;
      logic [31:0] d;
      logic        dir;
      logic [4:0]  s;
      do_reset();
      accepted = 0;
      for (int k = 0; k < 7; k++) begin
         d   = $urandom;
         dir = 1'($urandom_range(0, 1));
         s   = 5'($urandom_range(0, 31));
         if (k == 0) first_res = rotate(d, dir, s);
         apply_stimulus(1'b1, d, dir, s, 1'b0);
         if (last_ready === 1'b1) accepted++;
         if (k >= 1) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== first_res) begin
               n_fail++; $display("[TB] FAIL full_hold%0d: got valid=%b data=%h want valid=1 data=%h",
                                  k, out_valid, out_data, first_res);
            end
         end
      end
      n_checks++;
      if (accepted != DEPTH + 1) begin n_fail++; $display("[TB] FAIL full_accepted: got %0d want %0d", accepted, DEPTH + 1); end
      n_checks++;
      if (level !== 3'd4 || in_ready !== 1'b0) begin
         n_fail++; $display("[TB] FAIL full_level: got level=%0d ready=%b want level=4 ready=0", level, in_ready);
      end
      for (int k = 0; k < 6; k++) begin
         apply_stimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
         n_checks++;
         if (out_valid !== m_valid || (m_valid && out_data !== m_data)) begin
            n_fail++; $display("[TB] FAIL full_drain%0d: got valid=%b data=%h want valid=%b data=%h",
                               k, out_valid, out_data, m_valid, m_data);
         end
      end
      n_checks++;
      if (done_cnt !== 4'd5) begin n_fail++; $display("[TB] FAIL full_done: got %0d want 5", done_cnt); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int k = 0; k < 3; k++) apply_stimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0);
      n_checks++;
      if (level !== 3'd2) begin n_fail++; $display("[TB] FAIL simul_setup_level: got %0d want 2", level); end
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b1);
         n_checks++;
         if (level !== 3'd2 || out_data !== m_data) begin
            n_fail++; $display("[TB] FAIL simul_step%0d: got level=%0d data=%h want level=2 data=%h",
                               k, level, out_data, m_data);
         end
      end
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
         n_checks++;
         if (out_valid !== m_valid || (m_valid && out_data !== m_data)) begin
            n_fail++; $display("[TB] FAIL simul_drain%0d: got valid=%b data=%h want valid=%b data=%h",
                               k, out_valid, out_data, m_valid, m_data);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      apply_stimulus(1'b1, 32'hA5A5_0F0F, 1'b0, 5'd3, 1'b0);
      apply_stimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      apply_stimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      for (int k = 0; k < 4; k++) apply_stimulus(1'b1, $urandom, 1'b1, 5'd7, 1'b0);
      n_checks++;
      if (level !== 3'd3 || out_valid !== 1'b1 || done_cnt !== 4'd1) begin
         n_fail++; $display("[TB] FAIL mid_setup: got level=%0d valid=%b done=%0d want 3/1/1", level, out_valid, done_cnt);
      end
      do_reset();
      n_checks++;
      if (level !== 3'd0 || out_valid !== 1'b0 || out_data !== 32'd0 || done_cnt !== 4'd0 || in_ready !== 1'b1) begin
         n_fail++; $display("[TB] FAIL mid_reset: got level=%0d valid=%b data=%h done=%0d ready=%b want 0/0/0/0/1",
                            level, out_valid, out_data, done_cnt, in_ready);
      end
      apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1);
      apply_stimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
         n_fail++; $display("[TB] FAIL mid_after: got valid=%b data=%h want valid=1 data=deadbeef", out_valid, out_data);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 0; k < 21; k++) begin
         if (k < 17) apply_stimulus(1'b1, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b1);
         else        apply_stimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
         n_checks++;
         if (out_valid !== m_valid || (m_valid && out_data !== m_data)) begin
            n_fail++; $display("[TB] FAIL wrap_order%0d: got valid=%b data=%h want valid=%b data=%h",
                               k, out_valid, out_data, m_valid, m_data);
         end
      end
      n_checks++;
      if (done_cnt !== 4'd1) begin n_fail++; $display("[TB] FAIL wrap_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_random();
      logic v;
      logic ordy;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         apply_stimulus(v, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ordy);
         n_checks++;
         if (level !== 3'(model_q.size()) || in_ready !== (model_q.size() < DEPTH)) begin
            n_fail++; $display("[TB] FAIL rand_level%0d: got level=%0d ready=%b want level=%0d",
                               k, level, in_ready, model_q.size());
         end
         n_checks++;
         if (out_valid !== m_valid || (m_valid && out_data !== m_data)) begin
            n_fail++; $display("[TB] FAIL rand_out%0d: got valid=%b data=%h want valid=%b data=%h",
                               k, out_valid, out_data, m_valid, m_data);
         end
         n_checks++;
         if (int'(done_cnt) != m_done) begin
            n_fail++; $display("[TB] FAIL rand_done%0d: got %0d want %0d", k, done_cnt, m_done);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      in_dir    = 1'b0;
      in_sh     = 5'd0;
      out_ready = 1'b0;
      m_valid   = 1'b0;
      m_data    = 32'd0;
      m_done    = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_simultaneous();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bsh_cmd_queue.md
Name: bsh_cmd_queue

Overview:
Command buffer and result-capture stage that sits directly upstream of the 32-bit combinational barrel rotator. It accepts rotate commands {data, dir, amount} over a valid/ready interface and holds them in a DEPTH-entry FIFO. The FIFO head drives the rotator inputs, and the block registers the rotator's combinational result into an output register with its own valid/ready handshake. This makes the rotator usable in pipelined, back-pressured datapaths.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2.
CNT_W, 16, width of the completed-command counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  command present.
in_ready  output  1  FIFO can accept; equals (count < DEPTH).
in_data  input  32  operand to rotate.
in_dir  input  1  1 = rotate right, 0 = rotate left.
in_sh  input  5  rotate amount, 0..31.
sh_data  output  32  to rotator data_in; FIFO head data (0 when empty).
sh_dir  output  1  to rotator dir; FIFO head dir (0 when empty).
sh_amt  output  5  to rotator sh; FIFO head amount (0 when empty).
sh_result  input  32  rotator data_out; purely combinational function of sh_*.
out_valid  output  1  registered result available.
out_ready  input  1  consumer accepts result.
out_data  output  32  registered rotated word.
level  output  clog2(DEPTH)+1  current FIFO occupancy.
done_cnt  output  CNT_W  results accepted by consumer; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at an edge): wr_ptr=0, rd_ptr=0, level=0, out_valid=0, out_data=0, done_cnt=0. FIFO storage contents are don't-care. Reset mid-operation discards all queued commands and any pending result; in_ready is 1 in the cycle after reset.
- push = in_valid & in_ready. in_ready depends only on level, never on out_ready or in_valid.
- pop = (level != 0) & (!out_valid | out_ready). On pop: out_data <= sh_result, out_valid <= 1, rd_ptr advances.
- If no pop and out_valid & out_ready: out_valid <= 0 and out_data holds its value.
- Simultaneous push and pop: level is unchanged, and both pointers advance. Push into an empty FIFO is not visible at the head until the next cycle (no bypass).
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH. Push at level=DEPTH is impossible because in_ready=0.
- Latency: command accepted at edge E0 appears at the head after E0, is captured at edge E1 when the output is free, and out_valid=1 is seen after E1. Minimum latency is 2 edges. Sustained throughput is 1 command/cycle with out_ready held at 1.
- Back-pressure: with out_ready=0, the output register holds one result and the FIFO holds DEPTH more. The total accepted before in_ready drops is DEPTH+1.
- out_data and out_valid must stay stable while out_valid=1 and out_ready=0.
- done_cnt increments on each cycle with out_valid & out_ready, and wraps from all-ones to 0.
- Commands are processed strictly in FIFO order. Amount 0 passes data unchanged (the rotator result is used as-is). No reordering and no dropping except on reset.

Test Plan:
- Single command: push data=0x80000001, dir=1, sh=1 with out_ready=1 → after 2 edges out_valid=1, out_data=0xC0000000, then done_cnt=1.
- Back-to-back: push 0x12345678 left 4, then 0x12345678 right 8, then 0x000000FF left 16 in consecutive cycles with out_ready=1 → out_data sequence 0x23456781, 0x78123456, 0x00FF0000 on consecutive cycles, with out_valid continuously high for 3 cycles.
- Full: out_ready=0, push continuously → exactly 5 accepted, then in_ready=0 and level=4. out_data stays equal to the first result. Raising out_ready drains all 5 in order, and done_cnt=5.
- Simultaneous push/pop at level=2 with out_ready=1 → level stays 2 and order is preserved.
- Reset mid-stream: level=3 and out_valid=1, assert rst for 1 cycle → level=0, out_valid=0, out_data=0, done_cnt=0, in_ready=1. A subsequent push of 0xDEADBEEF, dir=0, sh=0 yields out_data=0xDEADBEEF.
- Wrap: with CNT_W=4, complete 17 commands → done_cnt=1. With DEPTH=4, push/pop 10 commands with pointers wrapping → data order intact.
